uart_tx_fifo: RTL and testbench

Buffered UART transmitter that complements the existing UART receive path. Software or a DMA pushes bytes through a valid/ready stream into an internal FIFO. The block serialises each byte LSB-first on tx_o as start, 8 data bits, optional parity, then 1 or 2 stop bits. Timing uses its own x16 oversampling baud generator, programmed with the same bauds_lim_i value as the receiver so both ends run at identical rates.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_sync_fifo.sv | 61 ++++++
 rtl/uart_tx_fifo.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path (and the future RX buffer).
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO: rdata_o always presents the head entry.
// Push when full and pop when empty are ignored; no same-cycle bypass.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    if (push_ok && !pop_ok) level_d = level_q + 1'b1;
    else if (!push_ok && pop_ok) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed, LSB-first, optional parity, 1/2 stop bits.
// Define UART_TX_BREAK_EN to add the break_i line-break input.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tx_en_i,
`ifdef UART_TX_BREAK_EN
  input  logic             break_i,
`endif
  input  logic             parity_en_i,
  input  logic             parity_odd_i,
  input  logic             two_stop_i,
  input  logic [15:0]      bauds_lim_i,
  input  logic             s_valid_i,
  input  logic [7:0]       s_data_i,
  output logic             s_ready_o,
  output logic             tx_o,
  output logic             busy_o,
  output logic [LVL_W-1:0] fifo_level_o,
  output logic             tx_done_o
);

  // Stream handshake: a byte transfers on any clock where s_valid_i && s_ready_o.
  tx_state_e   state_q, state_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]  tick_cnt_q, tick_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic        two_stop_q, two_stop_d;

  logic        baud_tick, bit_end, stop_last, start_ok, baud_clr;
  logic        fifo_pop, fifo_empty, fifo_full;
  logic [7:0]  fifo_rdata;
  logic        brk_req, brk_hold;

  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (s_valid_i & s_ready_o),
    .pop_i   (fifo_pop),
    .wdata_i (s_data_i),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

  assign s_ready_o = ~fifo_full;

`ifdef UART_TX_BREAK_EN
  logic brk_hold_q, brk_hold_d;

  assign brk_req  = break_i;
  assign brk_hold = brk_hold_q;

  // After break_i falls, one idle bit period of mark is sent before the next pop.
  always_comb begin
    brk_hold_d = brk_hold_q;
    if (state_q == IDLE) begin
      if (break_i) brk_hold_d = 1'b1;
      else if (bit_end) brk_hold_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) brk_hold_q <= 1'b0;
    else       brk_hold_q <= brk_hold_d;
  end
`else
  assign brk_req  = 1'b0;
  assign brk_hold = 1'b0;
`endif

  assign baud_tick = tx_en_i & (baud_cnt_q == bauds_lim_i);
  assign bit_end   = baud_tick & (tick_cnt_q == 4'(OVERSAMPLE - 1));
  assign stop_last = (bit_idx_q[0] == two_stop_q);
  assign start_ok  = tx_en_i & ~fifo_empty & ~brk_req & (~brk_hold | bit_end);
  // Holding the divider at zero while idle makes every frame's start bit full length.
  assign baud_clr  = (state_q == IDLE) & (brk_req | ~brk_hold);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = START;
      START:   if (bit_end) state_d = DATA;
      DATA:    if (bit_end && bit_idx_q == 3'd7) state_d = parity_en_i ? PARITY : STOP;
      PARITY:  if (bit_end) state_d = STOP;
      STOP:    if (bit_end && stop_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    fifo_pop  = (state_q == IDLE) & start_ok;
    busy_o    = (state_q != IDLE);
    tx_done_o = (state_q == STOP) & bit_end & stop_last;
    tx_o      = 1'b1;
    unique case (state_q)
      IDLE:    tx_o = ~brk_req;
      START:   tx_o = 1'b0;
      DATA:    tx_o = shift_q[0];
      PARITY:  tx_o = par_q;
      STOP:    tx_o = 1'b1;
      default: tx_o = 1'b1;
    endcase
  end

  always_comb begin
    baud_cnt_d = baud_cnt_q;
    if (baud_clr) baud_cnt_d = '0;
    else if (baud_tick) baud_cnt_d = '0;
    else if (tx_en_i) baud_cnt_d = baud_cnt_q + 16'd1;

    tick_cnt_d = tick_cnt_q;
    if (state_d != state_q || baud_clr) tick_cnt_d = '0;
    else if (baud_tick) tick_cnt_d = tick_cnt_q + 4'd1;

    bit_idx_d = bit_idx_q;
    if (state_d != state_q) bit_idx_d = '0;
    else if (bit_end) bit_idx_d = bit_idx_q + 3'd1;

    shift_d    = shift_q;
    par_d      = par_q;
    two_stop_d = two_stop_q;
    if (fifo_pop) begin
      shift_d    = fifo_rdata;
      par_d      = calc_parity(fifo_rdata, parity_odd_i);
      two_stop_d = two_stop_i;
    end else if (state_q == DATA && bit_end) begin
      shift_d = {1'b0, shift_q[7:1]};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      baud_cnt_q <= '0;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      two_stop_q <= 1'b0;
    end else begin
      baud_cnt_q <= baud_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      two_stop_q <= two_stop_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo; break test is built when UART_TX_BREAK_EN is defined.
module tb_uart_tx_fifo;

  logic        clk;
  logic        rst_i;
  logic        tx_en;
  logic        parity_en;
  logic        parity_odd;
  logic        two_stop;
  logic [15:0] bauds_lim;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready_o;
  logic        tx_o;
  logic        busy_o;
  logic [4:0]  fifo_level_o;
  logic        tx_done_o;
`ifdef UART_TX_BREAK_EN
  logic        break_i;
`endif

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(.FIFO_DEPTH(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .tx_en_i      (tx_en),
`ifdef UART_TX_BREAK_EN
    .break_i      (break_i),
`endif
    .parity_en_i  (parity_en),
    .parity_odd_i (parity_odd),
    .two_stop_i   (two_stop),
    .bauds_lim_i  (bauds_lim),
    .s_valid_i    (s_valid),
    .s_data_i     (s_data),
    .s_ready_o    (s_ready_o),
    .tx_o         (tx_o),
    .busy_o       (busy_o),
    .fifo_level_o (fifo_level_o),
    .tx_done_o    (tx_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_byte(input logic [7:0] b);
    s_valid = 1'b1;
    s_data  = b;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Walks one frame cycle by cycle against a hand-built bit list; optional pause inside it.
  task automatic check_frame(input logic [7:0] b, input logic pen, input logic pbit,
                             input logic tstop, input int lim, input int max_wait,
                             input int pause_at, input int pause_len, input string name);
    logic exp_bits [12];
    logic exp_done;
    logic got_tx;
    int   nb, p, t, bad;
    nb = 10 + int'(pen) + int'(tstop);
    p  = 16 * (lim + 1);
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
    exp_bits[9] = pen ? pbit : 1'b1;
    for (int i = 10; i < 12; i++) exp_bits[i] = 1'b1;
    t = 0;
    while (tx_o !== 1'b0 && t < max_wait) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (tx_o !== 1'b0) begin
      errors++;
      $display("FAIL %s start: tx_o=%b required 0 within %0d cycles", name, tx_o, max_wait);
      return;
    end
    for (int k = 0; k < nb; k++) begin
      bad = 0;
      got_tx = exp_bits[k];
      for (int c = 0; c < p; c++) begin
        exp_done = (k == nb - 1) && (c == p - 1);
        if (tx_o !== exp_bits[k] || tx_done_o !== exp_done) begin
          bad++;
          got_tx = tx_o;
        end
        if (k * p + c == pause_at) begin
          tx_en = 1'b0;
          repeat (pause_len) begin
            @(negedge clk);
            if (tx_o !== exp_bits[k] || tx_done_o !== 1'b0 || busy_o !== 1'b1) begin
              bad++;
              got_tx = tx_o;
            end
          end
          tx_en = 1'b1;
        end
        @(negedge clk);
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL %s bit %0d: %0d bad cycles, tx_o=%b required %b (tx_done at last cycle only)",
                 name, k, bad, got_tx, exp_bits[k]);
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    checks++; if (tx_o !== 1'b1) begin errors++; $display("FAIL reset tx_o: got %b required 1", tx_o); end
    checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL reset s_ready: got %b required 1", s_ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset busy: got %b required 0", busy_o); end
    checks++; if (fifo_level_o !== 5'd0) begin errors++; $display("FAIL reset level: got %0d required 0", fifo_level_o); end
    checks++; if (tx_done_o !== 1'b0) begin errors++; $display("FAIL reset tx_done: got %b required 0", tx_done_o); end
  endtask

  task automatic test_basic_8n1();
    bauds_lim = 16'd0; parity_en = 1'b0; two_stop = 1'b0; tx_en = 1'b1;
    push_byte(8'hA5);
    checks++; if (tx_o !== 1'b1) begin errors++; $display("FAIL basic pre-start tx_o: got %b required 1", tx_o); end
    checks++; if (fifo_level_o !== 5'd1) begin errors++; $display("FAIL basic level after push: got %0d required 1", fifo_level_o); end
    check_frame(8'hA5, 1'b0, 1'b0, 1'b0, 0, 1, -1, 0, "basic_8n1");
    checks++; if (busy_o !== 1'b0 || fifo_level_o !== 5'd0) begin
      errors++; $display("FAIL basic end: busy=%b level=%0d required 0/0", busy_o, fifo_level_o);
    end
  endtask

  task automatic test_parity();
    bauds_lim = 16'd0; parity_en = 1'b1; two_stop = 1'b0;
    parity_odd = 1'b0;
    push_byte(8'hA5);
    check_frame(8'hA5, 1'b1, 1'b0, 1'b0, 0, 1, -1, 0, "parity_even");
    parity_odd = 1'b1;
    push_byte(8'hA5);
    check_frame(8'hA5, 1'b1, 1'b1, 1'b0, 0, 1, -1, 0, "parity_odd");
    parity_en = 1'b0; parity_odd = 1'b0;
  endtask

  task automatic test_back_to_back();
    int bad;
    bauds_lim = 16'd0; tx_en = 1'b0;
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    checks++; if (fifo_level_o !== 5'd16) begin errors++; $display("FAIL full level: got %0d required 16", fifo_level_o); end
    checks++; if (s_ready_o !== 1'b0) begin errors++; $display("FAIL full s_ready: got %b required 0", s_ready_o); end
    checks++; if (busy_o !== 1'b0 || tx_o !== 1'b1) begin
      errors++; $display("FAIL disabled idle: busy=%b tx_o=%b required 0/1", busy_o, tx_o);
    end
    s_valid = 1'b1; s_data = 8'h10;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (fifo_level_o !== 5'd16 || s_ready_o !== 1'b0) bad++;
    end
    s_valid = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL held push: %0d cycles level=%0d required 16", bad, fifo_level_o); end
    tx_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_frame(8'(i), 1'b0, 1'b0, 1'b0, 0, 1, -1, 0, "back_to_back");
      if (i < 15) begin
        checks++;
        if (tx_o !== 1'b1 || busy_o !== 1'b0) begin
          errors++; $display("FAIL gap after frame %0d: tx_o=%b busy=%b required 1/0", i, tx_o, busy_o);
        end
      end
    end
    checks++; if (fifo_level_o !== 5'd0 || s_ready_o !== 1'b1) begin
      errors++; $display("FAIL drained: level=%0d s_ready=%b required 0/1", fifo_level_o, s_ready_o);
    end
  endtask

  task automatic test_divider_two_stop();
    bauds_lim = 16'd3; two_stop = 1'b1;
    push_byte(8'h3C);
    check_frame(8'h3C, 1'b0, 1'b0, 1'b1, 3, 1, -1, 0, "div3_2stop");
    two_stop = 1'b0; bauds_lim = 16'd0;
  endtask

  task automatic test_pause();
    bauds_lim = 16'd1;
    push_byte(8'h96);
    check_frame(8'h96, 1'b0, 1'b0, 1'b0, 1, 1, 103, 40, "pause");
    bauds_lim = 16'd0;
  endtask

  task automatic test_reset_midframe();
    int bad;
    bauds_lim = 16'd0; tx_en = 1'b1;
    push_byte(8'h00);
    push_byte(8'hFF);
    repeat (30) @(negedge clk);
    checks++; if (busy_o !== 1'b1 || tx_o !== 1'b0 || fifo_level_o !== 5'd1) begin
      errors++; $display("FAIL pre-reset: busy=%b tx_o=%b level=%0d required 1/0/1", busy_o, tx_o, fifo_level_o);
    end
    rst_i = 1'b1;
    #1;
    checks++; if (tx_o !== 1'b1) begin errors++; $display("FAIL async reset tx_o: got %b required 1", tx_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL async reset busy: got %b required 0", busy_o); end
    checks++; if (fifo_level_o !== 5'd0) begin errors++; $display("FAIL async reset level: got %0d required 0", fifo_level_o); end
    @(negedge clk);
    rst_i = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx_o !== 1'b1 || busy_o !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL post-reset idle: %0d bad cycles, tx_o=%b required 1", bad, tx_o); end
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break();
    int bad;
    bauds_lim = 16'd0; tx_en = 1'b1;
    break_i = 1'b1;
    push_byte(8'hA5);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_o !== 1'b0 || busy_o !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL break low: %0d bad cycles, tx_o=%b required 0", bad, tx_o); end
    break_i = 1'b0;
    #1;
    bad = 0;
    if (tx_o !== 1'b1 || busy_o !== 1'b0) bad++;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      if (tx_o !== 1'b1 || busy_o !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL break mark: %0d bad cycles, tx_o=%b required 1", bad, tx_o); end
    @(negedge clk);
    check_frame(8'hA5, 1'b0, 1'b0, 1'b0, 0, 0, -1, 0, "after_break");
  endtask
`endif

  initial begin
    rst_i = 1'b1; tx_en = 1'b0; parity_en = 1'b0; parity_odd = 1'b0;
    two_stop = 1'b0; bauds_lim = 16'd0; s_valid = 1'b0; s_data = 8'h00;
`ifdef UART_TX_BREAK_EN
    break_i = 1'b0;
`endif
    test_reset();
    test_basic_8n1();
    test_parity();
    test_back_to_back();
    test_divider_two_stop();
    test_pause();
    test_reset_midframe();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
